// File: rtl/dds_dac_pkg.sv
`timescale 1ns/1ps
// dds_dac_pkg
// Shared definitions for the DDS-to-DAC serial writer: frame geometry,
// writer FSM states, DAC command bytes and the frame-building helper.
package dds_dac_pkg;

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CMD_W   = 8;

  localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE = 8'h00;
  localparam logic [CMD_W-1:0] CMD_POWER_DOWN   = 8'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dac_state_e;

  // Command byte first, then the sample; flip_msb converts a two's
  // complement sample to offset binary.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [CMD_W-1:0]  cmd,
    input logic [DATA_W-1:0] sample,
    input logic              flip_msb
  );
    return {cmd, sample ^ {flip_msb, {(DATA_W-1){1'b0}}}};
  endfunction

endpackage

// File: rtl/dac_clk_div.sv
`timescale 1ns/1ps
// dac_clk_div
// sclk half-period divider. Counts 0..CLK_DIV-1 while enabled; at the
// terminal count it raises tick and toggles sclk. clr restarts the count
// and forces sclk high (its idle level).
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable (frame shifting)
//   clr      : restart count, sclk back to idle high
//   tick     : terminal count reached this cycle (sclk toggles on this edge)
//   sclk     : serial clock output
module dac_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic sclk
);

  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;

  assign tick = en && (cnt_q == TERM);
  assign sclk = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/dac_spi_writer.sv
`timescale 1ns/1ps
// dac_spi_writer
// Ships each accepted 16-bit DDS sample to a serial DAC as a 24-bit frame
// {cmd, sample}, MSB first, framed by sync_n with sclk idling high.
//   clk, reset     : clock, asynchronous active-high reset
//   sample_in      : waveform sample (MSB inverted at capture if TWOS_COMP)
//   cmd_in         : DAC command byte, captured with the sample
//   sample_valid   : sample_in/cmd_in valid
//   sample_ready   : writer idle, accepts this cycle
//   busy           : frame or inter-frame gap in progress
//   frame_done     : one-cycle pulse as sync_n rises at frame end
//   sync_n         : DAC frame select, active low
//   sclk           : serial clock, DAC samples mosi on its falling edge
//   mosi           : serial data
module dac_spi_writer
  import dds_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TWOS_COMP  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic [7:0]  cmd_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_n,
  output logic        sclk,
  output logic        mosi
);

  localparam logic       FLIP     = (TWOS_COMP != 0);
  localparam logic [7:0] GAP_TERM = 8'(GAP_CYCLES - 1);

  dac_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [4:0]         bit_q, bit_d;
  logic [7:0]         gap_q, gap_d;
  logic               sync_n_q, sync_n_d;
  logic               done_q, done_d;

  logic               accept;
  logic               div_tick;
  logic               sclk_w;
  logic               rise;
  logic [FRAME_W-1:0] frame_load;

  assign accept     = (state_q == IDLE) && sample_valid;
  assign frame_load = build_frame(cmd_in, sample_in, FLIP);
  // A tick while sclk is low is the rising toggle that closes a bit.
  assign rise       = div_tick && !sclk_w;

  dac_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (reset),
    .en   (state_q == SHIFT),
    .clr  (accept),
    .tick (div_tick),
    .sclk (sclk_w)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sync_n_d = sync_n_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          shreg_d  = frame_load;
          bit_d    = '0;
          sync_n_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          if (bit_q == 5'd23) begin
            // Clearing the shift register returns mosi to its idle 0.
            shreg_d  = '0;
            sync_n_d = 1'b1;
            done_d   = 1'b1;
            gap_d    = '0;
            state_d  = GAP;
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_TERM) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      sync_n_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sync_n_q <= sync_n_d;
      done_q   <= done_d;
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign frame_done   = done_q;
  assign sync_n       = sync_n_q;
  assign sclk         = sclk_w;
  assign mosi         = shreg_q[FRAME_W-1];

endmodule

// File: tb/tb_dac_spi_writer.sv
`timescale 1ns/1ps
module tb_dac_spi_writer;
  import dds_dac_pkg::*;

  localparam int NI = 4;
  localparam int unsigned CDIV [NI] = '{2, 2, 1, 3};
  localparam int unsigned GAPC [NI] = '{2, 2, 2, 5};
  localparam int unsigned TWOC [NI] = '{0, 1, 0, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [NI];
  logic [15:0] smp   [NI];
  logic [7:0]  cmd   [NI];
  logic        vld   [NI];
  logic        rdy   [NI];
  logic        bsy   [NI];
  logic        fdone [NI];
  logic        syncn [NI];
  logic        sclk  [NI];
  logic        mosi  [NI];
  logic        hold_mode [NI];
  int          frames_seen [NI];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input int inst, input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h at %0t", inst, name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int unsigned P = 48 * CDIV[g] + GAPC[g] + 1;

    dac_spi_writer #(
      .CLK_DIV    (CDIV[g]),
      .GAP_CYCLES (GAPC[g]),
      .TWOS_COMP  (TWOC[g])
    ) dut (
      .clk          (clk),
      .reset        (rst[g]),
      .sample_in    (smp[g]),
      .cmd_in       (cmd[g]),
      .sample_valid (vld[g]),
      .sample_ready (rdy[g]),
      .busy         (bsy[g]),
      .frame_done   (fdone[g]),
      .sync_n       (syncn[g]),
      .sclk         (sclk[g]),
      .mosi         (mosi[g])
    );

    // Reference model: a frame occupies the writer for P cycles from its
    // accept edge; any valid seen while free is accepted.
    logic [23:0] expq [$];
    int mcyc    = 0;
    int free_at = 0;

    initial begin
      forever begin
        @(posedge clk or posedge rst[g]);
        if (rst[g]) begin
          expq.delete();
          mcyc    = 0;
          free_at = 0;
        end else begin
          mcyc++;
          if (vld[g] && mcyc >= free_at) begin
            expq.push_back({cmd[g], smp[g] ^ ((TWOC[g] != 0) ? 16'h8000 : 16'h0000)});
            free_at = mcyc + int'(P);
          end
        end
      end
    end

    // Monitor: observes the serial lines and compares against the model.
    initial begin
      bit          in_fr = 0, have_rise = 0, have_fall = 0;
      bit          prev_sync = 1, prev_sclk = 1, exp_rdy, rose;
      int          lowcnt = 0, phcnt = 0, nfall = 0, hicnt = 0, since_fall = 0;
      logic [23:0] bits = '0, e;
      forever begin
        @(negedge clk);
        if (rst[g]) begin
          in_fr = 0; have_rise = 0; have_fall = 0; prev_sync = 1; prev_sclk = 1;
          chk(g, syncn[g] && sclk[g] && !mosi[g] && rdy[g] && !bsy[g] && !fdone[g],
              "reset_outputs", {26'd0, syncn[g], sclk[g], mosi[g], rdy[g], bsy[g], fdone[g]}, 32'h34);
        end else begin
          since_fall++;
          exp_rdy = (mcyc + 1 >= free_at);
          chk(g, rdy[g] == exp_rdy && bsy[g] == !exp_rdy, "ready_busy",
              {30'd0, rdy[g], bsy[g]}, {30'd0, exp_rdy, !exp_rdy});
          rose = syncn[g] && !prev_sync && in_fr;
          if (!syncn[g] && prev_sync) begin
            if (have_fall && hold_mode[g]) chk(g, since_fall == int'(P), "frame_period", since_fall, P);
            if (have_rise && hold_mode[g]) chk(g, hicnt == int'(GAPC[g]) + 1, "sync_high_time", hicnt, GAPC[g] + 1);
            have_fall = 1; since_fall = 0; in_fr = 1;
            lowcnt = 0; phcnt = 0; nfall = 0; bits = '0;
          end
          if (!syncn[g]) begin
            lowcnt++;
            if (lowcnt == 1) begin
              chk(g, sclk[g] == 1'b1, "first_phase_high", sclk[g], 1);
              phcnt = 1;
            end else if (sclk[g] == prev_sclk) begin
              phcnt++;
            end else begin
              chk(g, phcnt == int'(CDIV[g]), "sclk_phase_len", phcnt, CDIV[g]);
              if (!sclk[g]) begin
                bits = {bits[22:0], mosi[g]};
                nfall++;
              end
              phcnt = 1;
            end
          end else begin
            hicnt = rose ? 1 : hicnt + 1;
            chk(g, sclk[g] && !mosi[g], "idle_lines", {30'd0, sclk[g], mosi[g]}, 32'h2);
          end
          if (rose) begin
            chk(g, phcnt == int'(CDIV[g]), "last_phase_len", phcnt, CDIV[g]);
            chk(g, lowcnt == 48 * int'(CDIV[g]), "sync_low_len", lowcnt, 48 * CDIV[g]);
            chk(g, nfall == 24, "sclk_falls", nfall, 24);
            chk(g, fdone[g] == 1'b1, "frame_done_at_end", fdone[g], 1);
            if (expq.size() == 0) begin
              chk(g, 1'b0, "frame_unexpected", bits, 0);
            end else begin
              e = expq.pop_front();
              chk(g, bits == e, "frame_bits", bits, e);
            end
            frames_seen[g]++;
            in_fr = 0; have_rise = 1;
          end else if (fdone[g]) begin
            chk(g, 1'b0, "frame_done_spurious", 1, 0);
          end
          prev_sync = syncn[g];
          prev_sclk = sclk[g];
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] c, input logic [15:0] s);
    cmd[i] = c; smp[i] = s; vld[i] = 1'b1;
    step();
    vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (!rdy[i] && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) chk(i, 1'b0, "wait_ready_timeout", n, 2000);
  endtask

  task automatic rand_traffic(input int i, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      vld[i] = ($urandom_range(0, 3) == 0);
      smp[i] = 16'($urandom);
      cmd[i] = 8'($urandom);
      step();
    end
    vld[i] = 1'b0;
    wait_idle(i);
  endtask

  task automatic seq0();
    repeat (3) step();
    rst[0] = 1'b0;
    repeat (20) step();
    send(0, CMD_WRITE_UPDATE, 16'hA5C3);
    wait_idle(0);
    rand_traffic(0, 500);
    // Reset asynchronously, mid-cycle, about 10 cycles into a frame.
    send(0, 8'($urandom), 16'($urandom));
    repeat (9) step();
    chk(0, syncn[0] == 1'b0, "frame_in_flight", syncn[0], 0);
    #1 rst[0] = 1'b1;
    #1 chk(0, syncn[0] && sclk[0], "reset_immediate", {30'd0, syncn[0], sclk[0]}, 32'h3);
    repeat (2) step();
    rst[0] = 1'b0;
    step();
    send(0, CMD_WRITE_UPDATE, 16'h1234);
    wait_idle(0);
  endtask

  task automatic seq1();
    repeat (3) step();
    rst[1] = 1'b0;
    step();
    send(1, CMD_WRITE_UPDATE, 16'h8000);
    wait_idle(1);
    send(1, CMD_WRITE_UPDATE, 16'h7FFF);
    wait_idle(1);
    rand_traffic(1, 300);
  endtask

  task automatic seq2();
    hold_mode[2] = 1'b1;
    vld[2] = 1'b1;
    repeat (3) step();
    rst[2] = 1'b0;
    for (int k = 0; k < 330; k++) begin
      smp[2] = 16'($urandom);
      cmd[2] = 8'($urandom);
      step();
    end
    vld[2] = 1'b0;
    wait_idle(2);
  endtask

  task automatic seq3();
    hold_mode[3] = 1'b1;
    cmd[3] = CMD_POWER_DOWN;
    smp[3] = 16'h0001;
    vld[3] = 1'b1;
    repeat (3) step();
    rst[3] = 1'b0;
    repeat (450) step();
    for (int k = 0; k < 300; k++) begin
      smp[3] = 16'($urandom);
      cmd[3] = 8'($urandom);
      step();
    end
    vld[3] = 1'b0;
    wait_idle(3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; smp[i] = '0; cmd[i] = '0;
      hold_mode[i] = 1'b0; frames_seen[i] = 0;
    end
    fork
      seq0();
      seq1();
      seq2();
      seq3();
    join
    repeat (5) step();
    chk(0, inst[0].expq.size() == 0, "scoreboard_drained", inst[0].expq.size(), 0);
    chk(1, inst[1].expq.size() == 0, "scoreboard_drained", inst[1].expq.size(), 0);
    chk(2, inst[2].expq.size() == 0, "scoreboard_drained", inst[2].expq.size(), 0);
    chk(3, inst[3].expq.size() == 0, "scoreboard_drained", inst[3].expq.size(), 0);
    for (int i = 0; i < NI; i++)
      chk(i, frames_seen[i] >= 3, "frames_observed", frames_seen[i], 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
